// File: rtl/apb3_arb_pkg.sv
// Shared types and constants for the two-master APB3 arbiter.
package apb3_arb_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StSetup  = 2'b01,
    StAccess = 2'b10
  } arb_state_e;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_HW  = 1'b1;

  localparam int unsigned TmoCntW = 16;

endpackage

// File: rtl/rr_grant2.sv
// Two-way round-robin chooser; holds the index of the last granted port.
module rr_grant2
  import apb3_arb_pkg::*;
(
  input  logic       clk,
  input  logic       resetn,
  input  logic [1:0] req,
  input  logic       update,
  output logic       grant_valid,
  output logic       grant_idx,
  output logic       last_grant
);

  logic last_grant_q;

  always_comb begin
    grant_valid = |req;
    case (req)
      2'b11:   grant_idx = ~last_grant_q;
      2'b10:   grant_idx = PORT_HW;
      default: grant_idx = PORT_CPU;
    endcase
  end

  // Resetting to the HW port makes the CPU win the first tie.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      last_grant_q <= PORT_HW;
    end else if (update && grant_valid) begin
      last_grant_q <= grant_idx;
    end
  end

  assign last_grant = last_grant_q;

endmodule

// File: rtl/apb3_master_arbiter.sv
// Shares one APB3 slave between the CPU (port 0) and HW engine (port 1), round-robin.
// Optional ACCESS timeout abort is built only when APB3_ARB_TIMEOUT_EN is defined.
module apb3_master_arbiter
  import apb3_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 12,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [ADDR_WIDTH-1:0] s0_PADDR,
  input  logic                  s0_PSEL,
  input  logic                  s0_PENABLE,
  input  logic                  s0_PWRITE,
  input  logic [DATA_WIDTH-1:0] s0_PWDATA,
  output logic                  s0_PREADY,
  output logic [DATA_WIDTH-1:0] s0_PRDATA,
  output logic                  s0_PSLVERROR,
  input  logic [ADDR_WIDTH-1:0] s1_PADDR,
  input  logic                  s1_PSEL,
  input  logic                  s1_PENABLE,
  input  logic                  s1_PWRITE,
  input  logic [DATA_WIDTH-1:0] s1_PWDATA,
  output logic                  s1_PREADY,
  output logic [DATA_WIDTH-1:0] s1_PRDATA,
  output logic                  s1_PSLVERROR,
  output logic [ADDR_WIDTH-1:0] m_PADDR,
  output logic                  m_PSEL,
  output logic                  m_PENABLE,
  output logic                  m_PWRITE,
  output logic [DATA_WIDTH-1:0] m_PWDATA,
  input  logic                  m_PREADY,
  input  logic                  m_PSLVERROR,
  input  logic [DATA_WIDTH-1:0] m_PRDATA,
  output logic                  grant
);

  arb_state_e state_q, state_d;

  logic [1:0]            req;
  logic                  grant_valid;
  logic                  grant_idx;
  logic                  last_grant;
  logic                  take;
  logic                  xfer_done;
  logic                  timeout_hit;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic                  rsp_err;

  logic                  m_psel_q, m_penable_q, m_pwrite_q;
  logic [ADDR_WIDTH-1:0] m_paddr_q;
  logic [DATA_WIDTH-1:0] m_pwdata_q;

  assign req       = {s1_PSEL, s0_PSEL};
  assign take      = (state_q == StIdle) && grant_valid;
  assign xfer_done = (state_q == StAccess) && m_PREADY;

  rr_grant2 u_rr_grant2 (
    .clk         (clk),
    .resetn      (resetn),
    .req         (req),
    .update      (take),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx),
    .last_grant  (last_grant)
  );

  assign grant = last_grant;

`ifdef APB3_ARB_TIMEOUT_EN
  localparam logic [TmoCntW-1:0] TmoLimit = TmoCntW'(TIMEOUT_CYCLES);

  logic [TmoCntW-1:0] tmo_cnt_q;

  // Held at zero outside ACCESS, so every ACCESS phase starts counting from zero.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tmo_cnt_q <= '0;
    end else if (state_q != StAccess) begin
      tmo_cnt_q <= '0;
    end else if (!m_PREADY && (tmo_cnt_q != TmoLimit)) begin
      tmo_cnt_q <= tmo_cnt_q + 1'b1;
    end
  end

  assign timeout_hit = (state_q == StAccess) && !m_PREADY && (tmo_cnt_q == TmoLimit);
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout_hit        = 1'b0;
`endif

  always_comb begin
    state_d = StIdle;
    case (state_q)
      StIdle:   state_d = grant_valid ? StSetup : StIdle;
      StSetup:  state_d = StAccess;
      StAccess: state_d = (m_PREADY || timeout_hit) ? StIdle : StAccess;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= StIdle;
      m_psel_q    <= 1'b0;
      m_penable_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      m_psel_q    <= (state_d == StSetup) || (state_d == StAccess);
      m_penable_q <= (state_d == StAccess);
    end
  end

  // Address/data are captured once at grant and held until the next grant.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_paddr_q  <= '0;
      m_pwrite_q <= 1'b0;
      m_pwdata_q <= '0;
    end else if (take) begin
      m_paddr_q  <= grant_idx ? s1_PADDR  : s0_PADDR;
      m_pwrite_q <= grant_idx ? s1_PWRITE : s0_PWRITE;
      m_pwdata_q <= grant_idx ? s1_PWDATA : s0_PWDATA;
    end
  end

  assign m_PSEL    = m_psel_q;
  assign m_PENABLE = m_penable_q;
  assign m_PADDR   = m_paddr_q;
  assign m_PWRITE  = m_pwrite_q;
  assign m_PWDATA  = m_pwdata_q;

  assign rsp_data = xfer_done ? m_PRDATA : '0;
  assign rsp_err  = xfer_done ? m_PSLVERROR : timeout_hit;

  // A port that dropped PSEL mid-transfer gets nothing back; the response is discarded.
  always_comb begin
    s0_PREADY    = 1'b0;
    s0_PRDATA    = '0;
    s0_PSLVERROR = 1'b0;
    s1_PREADY    = 1'b0;
    s1_PRDATA    = '0;
    s1_PSLVERROR = 1'b0;
    if (last_grant == PORT_CPU) begin
      s0_PREADY    = (xfer_done && s0_PENABLE && s0_PSEL) || timeout_hit;
      s0_PRDATA    = s0_PSEL ? rsp_data : '0;
      s0_PSLVERROR = s0_PSEL && rsp_err;
    end else begin
      s1_PREADY    = (xfer_done && s1_PENABLE && s1_PSEL) || timeout_hit;
      s1_PRDATA    = s1_PSEL ? rsp_data : '0;
      s1_PSLVERROR = s1_PSEL && rsp_err;
    end
  end

endmodule

// File: tb/tb_apb3_master_arbiter.sv
// Self-checking bench for apb3_master_arbiter: directed steps plus random two-master traffic.
module tb_apb3_master_arbiter;

  localparam int unsigned AW  = 12;
  localparam int unsigned DW  = 32;
  localparam int unsigned TMO = 8;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]    s_psel, s_penable, s_pwrite;
  logic [AW-1:0] s_paddr [2];
  logic [DW-1:0] s_pwdata [2];
  logic          s0_pready, s1_pready, s0_perr, s1_perr;
  logic [DW-1:0] s0_prdata, s1_prdata;
  logic [AW-1:0] m_paddr;
  logic          m_psel, m_penable, m_pwrite, m_pready, m_pslverr, grant;
  logic [DW-1:0] m_pwdata, m_prdata;

  int checks = 0;
  int errors = 0;
  int lat;

  // Slave device contents and the bench's expectation of them.
  logic [DW-1:0] slave_mem [1024];
  logic [DW-1:0] model_mem [1024];
  bit            slave_hang = 1'b0;
  bit            slave_rand = 1'b0;
  int            slave_ws = 0;
  int            ws_left;
  logic [AW-1:0] cap_addr;
  logic [DW-1:0] cap_wdata;
  logic          cap_wr;
  int            order [$];

  apb3_master_arbiter #(
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (DW),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .s0_PADDR     (s_paddr[0]),
    .s0_PSEL      (s_psel[0]),
    .s0_PENABLE   (s_penable[0]),
    .s0_PWRITE    (s_pwrite[0]),
    .s0_PWDATA    (s_pwdata[0]),
    .s0_PREADY    (s0_pready),
    .s0_PRDATA    (s0_prdata),
    .s0_PSLVERROR (s0_perr),
    .s1_PADDR     (s_paddr[1]),
    .s1_PSEL      (s_psel[1]),
    .s1_PENABLE   (s_penable[1]),
    .s1_PWRITE    (s_pwrite[1]),
    .s1_PWDATA    (s_pwdata[1]),
    .s1_PREADY    (s1_pready),
    .s1_PRDATA    (s1_prdata),
    .s1_PSLVERROR (s1_perr),
    .m_PADDR      (m_paddr),
    .m_PSEL       (m_psel),
    .m_PENABLE    (m_penable),
    .m_PWRITE     (m_pwrite),
    .m_PWDATA     (m_pwdata),
    .m_PREADY     (m_pready),
    .m_PSLVERROR  (m_pslverr),
    .m_PRDATA     (m_prdata),
    .grant        (grant)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic port_ready(input int p);
    return (p == 0) ? s0_pready : s1_pready;
  endfunction

  function automatic logic [DW-1:0] port_rdata(input int p);
    return (p == 0) ? s0_prdata : s1_prdata;
  endfunction

  function automatic logic port_err(input int p);
    return (p == 0) ? s0_perr : s1_perr;
  endfunction

  task automatic check_reset_vals();
    chk("rst_m_psel",    32'(m_psel),    32'h0);
    chk("rst_m_penable", 32'(m_penable), 32'h0);
    chk("rst_m_pwrite",  32'(m_pwrite),  32'h0);
    chk("rst_m_paddr",   32'(m_paddr),   32'h0);
    chk("rst_m_pwdata",  m_pwdata,       32'h0);
    chk("rst_s0_ready",  32'(s0_pready), 32'h0);
    chk("rst_s1_ready",  32'(s1_pready), 32'h0);
    chk("rst_s0_rdata",  s0_prdata,      32'h0);
    chk("rst_s1_rdata",  s1_prdata,      32'h0);
    chk("rst_s0_err",    32'(s0_perr),   32'h0);
    chk("rst_s1_err",    32'(s1_perr),   32'h0);
    chk("rst_grant",     32'(grant),     32'h1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_vals();
    resetn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // One upstream APB transfer; called and returns 1 time unit after a rising edge.
  task automatic apb_xfer(input int p, input logic wr, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wdata, input bit tmo, output int latency);
    bit   ok;
    logic exp_err;
    int   q;
    q = 1 - p;
    s_psel[p]    = 1'b1;
    s_penable[p] = 1'b0;
    s_pwrite[p]  = wr;
    s_paddr[p]   = addr;
    s_pwdata[p]  = wdata;
    latency = 0;
    ok = 1'b0;
    while (!ok && latency < 300) begin
      @(negedge clk);
      if (port_ready(p)) begin
        ok = 1'b1;
        chk("other_ready", 32'(port_ready(q)), 32'h0);
        chk("other_rdata", port_rdata(q), 32'h0);
        chk("other_err", 32'(port_err(q)), 32'h0);
        chk("grant_idx", 32'(grant), 32'(p));
        if (tmo) begin
          chk("tmo_err", 32'(port_err(p)), 32'h1);
          chk("tmo_rdata", port_rdata(p), 32'h0);
        end else begin
          chk("ready_with_m_ready", 32'(m_pready), 32'h1);
          exp_err = (addr[11:8] == 4'hE);
          chk("slverr", 32'(port_err(p)), 32'(exp_err));
          if (!wr && !exp_err) chk("rdata", port_rdata(p), model_mem[addr[11:2]]);
          if (wr && !exp_err) model_mem[addr[11:2]] = wdata;
        end
        order.push_back(p);
      end
      @(posedge clk);
      #1;
      if (!ok) begin
        s_penable[p] = 1'b1;
        latency++;
      end
    end
    chk("xfer_completed", 32'(ok), 32'h1);
    chk("min_latency", 32'(latency >= 2), 32'h1);
    s_psel[p]    = 1'b0;
    s_penable[p] = 1'b0;
  endtask

  task automatic run_master(input int p, input int n);
    int            gap;
    int            l;
    logic [AW-1:0] a;
    for (int i = 0; i < n; i++) begin
      gap = $urandom_range(0, 2);
      repeat (gap) begin
        @(posedge clk);
        #1;
      end
      if ($urandom_range(0, 7) == 0) a = 12'hE00 | AW'($urandom_range(0, 63) << 2);
      else                           a = AW'($urandom_range(0, 15) << 2);
      apb_xfer(p, 1'($urandom_range(0, 1)), a, $urandom, 1'b0, l);
    end
  endtask

  // Downstream register slave with configurable wait states.
  initial begin
    m_pready  = 1'b0;
    m_prdata  = '0;
    m_pslverr = 1'b0;
    ws_left   = 0;
    forever begin
      @(posedge clk);
      #1;
      m_pready  = 1'b0;
      m_prdata  = $urandom;
      m_pslverr = 1'($urandom_range(0, 1));
      if (resetn && m_psel && !m_penable) begin
        ws_left   = slave_rand ? int'($urandom_range(0, 3)) : slave_ws;
        cap_addr  = m_paddr;
        cap_wdata = m_pwdata;
        cap_wr    = m_pwrite;
      end else if (resetn && m_psel && m_penable) begin
        chk("stable_paddr", 32'(m_paddr), 32'(cap_addr));
        chk("stable_pwdata", m_pwdata, cap_wdata);
        chk("stable_pwrite", 32'(m_pwrite), 32'(cap_wr));
        if (!slave_hang && ws_left == 0) begin
          m_pready  = 1'b1;
          m_pslverr = (cap_addr[11:8] == 4'hE);
          if (!m_pslverr && cap_wr) slave_mem[cap_addr[11:2]] = cap_wdata;
          if (!m_pslverr && !cap_wr) m_prdata = slave_mem[cap_addr[11:2]];
        end else if (ws_left > 0) begin
          ws_left--;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    s_psel    = '0;
    s_penable = '0;
    s_pwrite  = '0;
    for (int i = 0; i < 2; i++) begin
      s_paddr[i]  = '0;
      s_pwdata[i] = '0;
    end
    for (int i = 0; i < 1024; i++) begin
      slave_mem[i] = '0;
      model_mem[i] = '0;
    end

    do_reset();

    // Lone CPU write: cycle-accurate phase check.
    fork
      apb_xfer(0, 1'b1, 12'h004, 32'h1, 1'b0, lat);
      begin
        @(negedge clk);
        chk("c0_m_psel", 32'(m_psel), 32'h0);
        @(negedge clk);
        chk("c1_m_psel", 32'(m_psel), 32'h1);
        chk("c1_m_penable", 32'(m_penable), 32'h0);
        chk("c1_m_paddr", 32'(m_paddr), 32'h004);
        chk("c1_m_pwdata", m_pwdata, 32'h1);
        chk("c1_m_pwrite", 32'(m_pwrite), 32'h1);
        @(negedge clk);
        chk("c2_m_penable", 32'(m_penable), 32'h1);
        chk("c2_s0_ready", 32'(s0_pready), 32'h1);
        chk("c2_s1_ready", 32'(s1_pready), 32'h0);
      end
    join
    chk("write_latency", 32'(lat), 32'd2);
    @(negedge clk);
    chk("hold_m_psel", 32'(m_psel), 32'h0);
    chk("hold_m_paddr", 32'(m_paddr), 32'h004);
    chk("hold_m_pwdata", m_pwdata, 32'h1);
    @(posedge clk);
    #1;

    // HW engine read with known slave contents.
    slave_mem[16] = 32'hABCD5678;
    model_mem[16] = 32'hABCD5678;
    fork
      apb_xfer(1, 1'b0, 12'h040, 32'h0, 1'b0, lat);
      begin
        repeat (3) @(negedge clk);
        chk("s1_read_data", s1_prdata, 32'hABCD5678);
        chk("s1_read_ready", 32'(s1_pready), 32'h1);
        chk("s0_rdata_zero", s0_prdata, 32'h0);
      end
    join

    // Continuous contention from reset: strict alternation starting at port 0.
    do_reset();
    order.delete();
    fork
      begin
        apb_xfer(0, 1'b1, 12'h008, 32'h11, 1'b0, lat);
        apb_xfer(0, 1'b0, 12'h008, 32'h0, 1'b0, lat);
      end
      begin
        apb_xfer(1, 1'b1, 12'h00C, 32'h22, 1'b0, lat);
        apb_xfer(1, 1'b0, 12'h004, 32'h0, 1'b0, lat);
      end
    join
    chk("rr_count", 32'(order.size()), 32'd4);
    for (int i = 0; i < 4 && i < order.size(); i++) chk("rr_order", 32'(order[i]), 32'(i % 2));

    // Five slave wait states add exactly five cycles.
    slave_ws = 5;
    apb_xfer(0, 1'b1, 12'h010, 32'hCAFE0005, 1'b0, lat);
    chk("ws5_latency", 32'(lat), 32'd7);
    slave_ws = 0;

    // Asynchronous reset during ACCESS.
    slave_hang   = 1'b1;
    s_psel[0]    = 1'b1;
    s_pwrite[0]  = 1'b1;
    s_paddr[0]   = 12'h014;
    s_pwdata[0]  = 32'h5A5A5A5A;
    @(posedge clk);
    #1;
    s_penable[0] = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("pre_rst_access", 32'(m_penable), 32'h1);
    #2;
    resetn = 1'b0;
    #1;
    check_reset_vals();
    @(posedge clk);
    #1;
    s_psel[0]    = 1'b0;
    s_penable[0] = 1'b0;
    slave_hang   = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;
    order.delete();
    fork
      apb_xfer(0, 1'b0, 12'h014, 32'h0, 1'b0, lat);
      apb_xfer(1, 1'b0, 12'h008, 32'h0, 1'b0, lat);
    join
    chk("post_rst_count", 32'(order.size()), 32'd2);
    if (order.size() > 0) chk("post_rst_first", 32'(order[0]), 32'h0);

    // Random concurrent traffic against the memory model.
    slave_rand = 1'b1;
    fork
      run_master(0, 40);
      run_master(1, 40);
    join
    slave_rand = 1'b0;

`ifdef APB3_ARB_TIMEOUT_EN
    slave_hang = 1'b1;
    apb_xfer(0, 1'b0, 12'h018, 32'h0, 1'b1, lat);
    chk("tmo_latency", 32'(lat), 32'(2 + TMO));
    @(negedge clk);
    chk("tmo_psel_drop", 32'(m_psel), 32'h0);
    slave_hang = 1'b0;
    @(posedge clk);
    #1;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
